memory_cmd_sequencer: RTL and testbench

//  Initiator side of the memory_controller instruction interface. Accepts a byte-wide

---
 rtl/memory_cmd_sequencer.sv | 135 +++++++++++++
 tb/tb_memory_cmd_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cmd_sequencer.sv
// Initiator for the memory_controller instruction interface: decodes a byte-wide command
// stream into read/write/wrapping-burst memory cycles and returns read bytes over valid/ready.
module memory_cmd_sequencer #(
    parameter int unsigned ADDR_BITS = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [7:0]           cmd_data_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    output logic [7:0]           rsp_data_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ADDR_BITS-1:0] mc_addr_o,
    output logic [7:0]           mc_wdata_o,
    output logic [3:0]           mc_inst_o,
    input  logic [7:0]           mc_rdata_i,
    output logic                 busy_o
);

    localparam logic [3:0] InstIdle  = 4'h0;
    localparam logic [3:0] InstRead  = 4'h1;
    localparam logic [3:0] InstWrite = 4'h8;

    typedef enum logic [2:0] {
        StIdle,
        StGetData,
        StWr,
        StGetCnt,
        StRdIssue,
        StRdWait,
        StResp
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [8:0]           remaining_q, remaining_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [7:0]           rsp_data_q, rsp_data_d;

    logic cmd_fire;
    logic rsp_fire;

    assign cmd_fire = cmd_valid_i & cmd_ready_o;
    assign rsp_fire = rsp_valid_o & rsp_ready_i;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    unique case (cmd_data_i[7:6])
                        2'b01: begin
                            addr_d      = cmd_data_i[ADDR_BITS-1:0];
                            remaining_d = 9'd1;
                            state_d     = StRdIssue;
                        end
                        2'b10: begin
                            addr_d  = cmd_data_i[ADDR_BITS-1:0];
                            state_d = StGetData;
                        end
                        2'b11: begin
                            addr_d  = cmd_data_i[ADDR_BITS-1:0];
                            state_d = StGetCnt;
                        end
                        default: ;  // NOP is discarded
                    endcase
                end
            end
            StGetData: begin
                if (cmd_fire) begin
                    wdata_d = cmd_data_i;
                    state_d = StWr;
                end
            end
            StWr: state_d = StIdle;
            StGetCnt: begin
                if (cmd_fire) begin
                    remaining_d = {1'b0, cmd_data_i} + 9'd1;
                    state_d     = StRdIssue;
                end
            end
            StRdIssue: state_d = StRdWait;
            StRdWait: begin
                rsp_data_d = mc_rdata_i;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_fire) begin
                    remaining_d = remaining_q - 9'd1;
                    // Address width makes the burst wrap modulo 2**ADDR_BITS for free
                    addr_d      = addr_q + ADDR_BITS'(1);
                    state_d     = (remaining_q == 9'd1) ? StIdle : StRdIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        mc_inst_o = InstIdle;
        if (state_q == StWr)      mc_inst_o = InstWrite;
        if (state_q == StRdIssue) mc_inst_o = InstRead;
    end

    assign cmd_ready_o = ~reset_i &
                         ((state_q == StIdle) | (state_q == StGetData) | (state_q == StGetCnt));
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_data_o  = rsp_data_q;
    assign mc_addr_o   = addr_q;
    assign mc_wdata_o  = wdata_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_memory_cmd_sequencer.sv
// Bench for memory_cmd_sequencer: directed scenarios plus random command traffic, checked
// against an array-based memory reference and a simple memory_controller stand-in.
module tb_memory_cmd_sequencer;

    localparam int unsigned AB = 2;
    localparam int unsigned MemWords = 1 << AB;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic [7:0]    cmd_data = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    rsp_data;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [AB-1:0] mc_addr;
    logic [7:0]    mc_wdata;
    logic [3:0]    mc_inst;
    logic [7:0]    mc_rdata = '0;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_wr     = 0;

    logic [7:0] env_mem [MemWords];  // memory_controller stand-in
    logic [7:0] ref_mem [MemWords];  // expected memory contents

    memory_cmd_sequencer #(.ADDR_BITS(AB)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .cmd_data_i (cmd_data),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .rsp_data_o (rsp_data),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .mc_addr_o  (mc_addr),
        .mc_wdata_o (mc_wdata),
        .mc_inst_o  (mc_inst),
        .mc_rdata_i (mc_rdata),
        .busy_o     (busy)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) begin
        if (mc_inst == 4'h8) begin
            env_mem[mc_addr] <= mc_wdata;
            n_wr <= n_wr + 1;
        end
        if (mc_inst == 4'h1) mc_rdata <= env_mem[mc_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        @(negedge clock_i);
        cmd_valid = 1'b1;
        cmd_data  = b;
        for (int n = 0; n < 50 && !done; n++) begin
            if (cmd_ready) begin
                @(posedge clock_i);
                done = 1;
            end else begin
                @(negedge clock_i);
            end
        end
        if (!done) check_eq("cmd_timeout", 0, 1);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp, input bit stall);
        bit done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clock_i);
            rsp_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rsp_valid && rsp_ready) begin
                check_eq(tag, {24'd0, rsp_data}, {24'd0, exp});
                done = 1;
            end
        end
        if (!done) check_eq({tag, "_timeout"}, 0, 1);
        @(posedge clock_i);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 0;
        for (int n = 0; n < 20 && !idle; n++) begin
            @(negedge clock_i);
            idle = !busy;
        end
        check_eq(tag, {31'd0, idle}, 1);
    endtask

    task automatic do_write(input int a, input logic [7:0] d, input logic [3:0] junk);
        send_byte({2'b10, junk, 2'(a)});
        send_byte(d);
        ref_mem[a] = d;
        wait_idle("write_idle");
    endtask

    task automatic do_burst(input int a, input int cnt, input bit stall);
        send_byte({2'b11, 4'($urandom), 2'(a)});
        send_byte(8'(cnt));
        for (int i = 0; i <= cnt; i++) recv_byte("burst_data", ref_mem[(a + i) % MemWords], stall);
        wait_idle("burst_idle");
    endtask

    task automatic do_read(input int a, input bit stall);
        send_byte({2'b01, 4'($urandom), 2'(a)});
        recv_byte("read_data", ref_mem[a], stall);
        wait_idle("read_idle");
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        #1;
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        check_eq("rst_mc_inst", {28'd0, mc_inst}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    initial begin
        int w0;
        bit seen;
        for (int i = 0; i < MemWords; i++) begin
            env_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end

        // Reset state and release
        #2;
        pulse_reset();
        #1 check_eq("ready_after_release", {31'd0, cmd_ready}, 1);

        // Single write, then read-back latency
        w0 = n_wr;
        send_byte(8'h82);
        send_byte(8'hA5);
        ref_mem[2] = 8'hA5;
        check_eq("wr_inst", {28'd0, mc_inst}, 32'h8);
        check_eq("wr_addr", {30'd0, mc_addr}, 2);
        check_eq("wr_wdata", {24'd0, mc_wdata}, 32'hA5);
        @(posedge clock_i);
        #1 check_eq("wr_inst_one_cycle", {28'd0, mc_inst}, 0);
        check_eq("wr_pulse_count", n_wr - w0, 1);
        send_byte(8'h42);
        check_eq("rd_issue_inst", {28'd0, mc_inst}, 1);
        check_eq("rd_valid_e1", {31'd0, rsp_valid}, 0);
        @(posedge clock_i);
        #1 check_eq("rd_valid_e2", {31'd0, rsp_valid}, 0);
        check_eq("rd_wait_inst", {28'd0, mc_inst}, 0);
        @(posedge clock_i);
        #1 check_eq("rd_valid_after_2", {31'd0, rsp_valid}, 1);
        recv_byte("rd_a5", 8'hA5, 0);
        wait_idle("rd_idle");

        // Fill memory and run a wrapping burst
        do_write(0, 8'h11, 4'h0);
        do_write(1, 8'h22, 4'hF);
        do_write(2, 8'h33, 4'h5);
        do_write(3, 8'h44, 4'hA);
        send_byte(8'hC3);
        send_byte(8'h04);
        recv_byte("wrap0", 8'h44, 0);
        recv_byte("wrap1", 8'h11, 0);
        recv_byte("wrap2", 8'h22, 0);
        recv_byte("wrap3", 8'h33, 0);
        recv_byte("wrap4", 8'h44, 0);
        wait_idle("wrap_idle");

        // Back-pressure holds the response and issues no reads
        send_byte(8'hC0);
        send_byte(8'h02);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clock_i);
            seen = rsp_valid;
        end
        check_eq("bp_first_valid", {31'd0, seen}, 1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clock_i);
            check_eq("bp_valid_held", {31'd0, rsp_valid}, 1);
            check_eq("bp_data_stable", {24'd0, rsp_data}, {24'd0, ref_mem[0]});
            check_eq("bp_no_inst", {28'd0, mc_inst}, 0);
        end
        for (int i = 0; i < 3; i++) recv_byte("bp_data", ref_mem[i], 1);
        wait_idle("bp_idle");

        // NOP is consumed without leaving idle
        send_byte(8'h00);
        check_eq("nop_busy", {31'd0, busy}, 0);
        check_eq("nop_inst", {28'd0, mc_inst}, 0);
        send_byte(8'h3D);
        check_eq("nop2_busy", {31'd0, busy}, 0);

        // Reset aborts a pending write in GET_DATA and in WR
        w0 = n_wr;
        send_byte(8'h81);
        check_eq("getdata_busy", {31'd0, busy}, 1);
        pulse_reset();
        send_byte(8'h81);
        send_byte(8'h5A);
        reset_i = 1'b1;
        #1 check_eq("wr_abort_inst", {28'd0, mc_inst}, 0);
        @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        check_eq("abort_no_write", n_wr - w0, 0);

        // Reset mid-burst drops the remainder
        send_byte(8'hC0);
        send_byte(8'h07);
        recv_byte("mid0", ref_mem[0], 0);
        recv_byte("mid1", ref_mem[1], 0);
        pulse_reset();
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock_i);
            if (rsp_valid || busy) seen = 1;
        end
        check_eq("mid_burst_dropped", {31'd0, seen}, 0);
        do_read(1, 0);
        check_eq("old_value_kept", {24'd0, ref_mem[1]}, 32'h22);

        // Full 256-read burst
        do_burst(2, 255, 0);

        // Random traffic
        for (int it = 0; it < 60; it++) begin
            int op = $urandom_range(0, 3);
            int a  = $urandom_range(0, MemWords - 1);
            case (op)
                0: begin
                    send_byte({2'b00, 6'($urandom)});
                    check_eq("rnd_nop_busy", {31'd0, busy}, 0);
                end
                1: do_read(a, 1);
                2: do_write(a, 8'($urandom), 4'($urandom));
                default: do_burst(a, $urandom_range(0, 6), 1);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
